// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic              neg;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier, quo, rem, dvs;

  logic              a_sgn, b_sgn, neg_in;
  logic              special, last, accept;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic [2*XLEN-1:0] prod_nx, prod_fin;
  logic [XLEN:0]     rem_sh, sub;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nx, quo_nx;
  logic [XLEN-1:0]   div_raw, div_val, mul_val;

  always_comb begin
    unique case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = a[XLEN-1];
        b_sgn = b[XLEN-1];
      end
      3'b010: begin
        a_sgn = a[XLEN-1];
        b_sgn = 1'b0;
      end
      default: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
    endcase
  end

  assign a_mag  = a_sgn ? -a : a;
  assign b_mag  = b_sgn ? -b : b;
  // Remainder takes the dividend sign; everything else the product sign.
  assign neg_in = (op[2] & op[1]) ? a_sgn : (a_sgn ^ b_sgn);

  always_comb begin
    special  = 1'b0;
    spec_val = '0;
    if (op[2] && b == '0) begin
      special  = 1'b1;
      spec_val = op[1] ? a : '1;
    end else if (op[2] && !op[0] && a == MIN && b == '1) begin
      special  = 1'b1;
      spec_val = op[1] ? '0 : MIN;
    end
  end

  assign last     = cnt == CNT_W'(XLEN - 1);
  assign accept   = (state == S_IDLE) & start & ~flush;

  assign prod_nx  = prod + (mplier[0] ? mcand : '0);
  assign prod_fin = neg ? -prod_nx : prod_nx;
  assign mul_val  = (op_q == 2'b00) ? prod_fin[XLEN-1:0]
                                    : prod_fin[2*XLEN-1:XLEN];

  assign rem_sh   = {rem, quo[XLEN-1]};
  assign sub      = rem_sh - {1'b0, dvs};
  assign q_bit    = rem_sh >= {1'b0, dvs};
  assign rem_nx   = XLEN'(q_bit ? sub : rem_sh);
  assign quo_nx   = {quo[XLEN-2:0], q_bit};
  assign div_raw  = op_q[1] ? rem_nx : quo_nx;
  assign div_val  = neg ? -div_raw : div_raw;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!op[2])       state_nx = S_MUL;
          else if (special) state_nx = S_DONE;
          else              state_nx = S_DIV;
        end
      end
      S_MUL:   if (last) state_nx = S_DONE;
      S_DIV:   if (last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  assign stall = ~rst & ~flush &
                 ((state == S_IDLE & start) |
                  state == S_MUL | state == S_DIV);
  assign done  = (state == S_DONE) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      neg    <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op[1:0];
      neg    <= neg_in;
      prod   <= '0;
      mcand  <= {{XLEN{1'b0}}, a_mag};
      mplier <= b_mag;
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      if (special) result <= spec_val;
    end else if (!flush && state == S_MUL) begin
      cnt    <= cnt + 1'b1;
      prod   <= prod_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) result <= mul_val;
    end else if (!flush && state == S_DIV) begin
      cnt    <= cnt + 1'b1;
      quo    <= quo_nx;
      rem    <= rem_nx;
      if (last) result <= div_val;
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Consumes forwarded operands and funct3 of an M-extension instruction held in the ID/EX register.
- Asserts stall to the hazard unit so IF/ID and ID/EX hold while it iterates.
- Delivers a 32-bit result to the EX result mux, which feeds the EX/MEM register.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  M-extension op valid in EX (decoded from control bundle in ID/EX)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  32  rs1 operand after forwarding mux
b  input  32  rs2 operand after forwarding mux
flush  input  1  synchronous abort from hazard unit
stall  output  1  combinational; holds PC, IF/ID, ID/EX; bubbles EX/MEM
done  output  1  result valid this cycle (one-cycle pulse)
result  output  32  registered result

Behaviour:
- Reset (async): state IDLE, counter 0, result 0, done 0, internal accumulators 0. stall 0 while rst high. Applies mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - Latch op, operand magnitudes and the result sign.
  - MUL/MULH/MULHSU/MULHU -> MUL.
  - DIV/DIVU/REM/REMU with normal operands -> DIV.
  - Special divide cases -> DONE directly.
- MUL:
  - Shift-add, one multiplier bit per cycle into a 64-bit product.
  - Counter runs 0..31; at 31 -> DONE.
- DIV:
  - Restoring divide, one quotient bit per cycle.
  - Counter runs 0..31; at 31 -> DONE.
- DONE:
  - result is registered on entry; done=1, stall=0.
  - Always -> IDLE next edge, even if start is still high (same instruction still in EX). This prevents retrigger.
- stall = (state==IDLE & start & !flush) | state==MUL | state==DIV; forced 0 when flush=1.
- Latency for a normal op:
  - Stall spans the IDLE-accept cycle plus 32 iteration cycles (33 cycles).
  - DONE follows in the 34th cycle with stall low, and the instruction advances.
- Special-case latency: stall 1 cycle (IDLE accept), then DONE.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - DIV/REM: signed; DIVU/REMU: unsigned.
  - Operate on magnitudes; negate the final value when the result sign is set.
- Result selection:
  - MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
  - DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV) -> 0x80000000; REM -> 0.
- flush:
  - In any state, the next state is IDLE; done is not asserted and result is unchanged.
  - Flush takes priority over start.
- result holds its value until the next DONE entry.
- done is never asserted outside DONE.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start held -> stall high 33 cycles, then done=1, result=0xFFFFFFEB; next cycle done=0, state IDLE.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with stall for 1 cycle then done:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=7, b=0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- rst asserted at iteration cycle 10 of a DIV -> stall and done 0 immediately, result 0. After release with start=0, the unit stays IDLE.
- Back-to-back pair MUL 3*4 then DIVU 9/3 (start continuously high) -> done pulses with 12, then 3. There is exactly one IDLE cycle between them, and no retrigger during DONE.
- flush at iteration cycle 5 of MUL -> stall 0 in the same cycle, IDLE next cycle, no done pulse, result unchanged.
